// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming(8,4) definitions: bit map and encode function.
// Imported by both the transmit encoder and the receive decoder.
package hamming_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CODE_W = 8;

    // Data bit positions inside the codeword
    localparam int unsigned P_D0 = 2;
    localparam int unsigned P_D1 = 4;
    localparam int unsigned P_D2 = 5;
    localparam int unsigned P_D3 = 6;

    // Parity bit positions; P_ALL makes total parity even
    localparam int unsigned P_P0  = 0;
    localparam int unsigned P_P1  = 1;
    localparam int unsigned P_P3  = 3;
    localparam int unsigned P_ALL = 7;

    function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c          = '0;
        c[P_D3]    = d[3];
        c[P_D2]    = d[2];
        c[P_D1]    = d[1];
        c[P_D0]    = d[0];
        c[P_P3]    = c[P_D3] ^ c[P_D2] ^ c[P_D1];
        c[P_P1]    = c[P_D3] ^ c[P_D2] ^ c[P_D0];
        c[P_P0]    = c[P_D3] ^ c[P_D1] ^ c[P_D0];
        c[P_ALL]   = ^c[CODE_W-2:0];
        return c;
    endfunction

endpackage

// File: rtl/hamming_encoder_tx_if.sv
// Data-in and codeword-out handshakes of the Hamming encoder.
// HAMMING_ERR_INJECT_EN adds the inj_en/inj_mask fault-injection controls.
interface hamming_encoder_tx_if;
    import hamming_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] code_out;
`ifdef HAMMING_ERR_INJECT_EN
    logic              inj_en;
    logic [CODE_W-1:0] inj_mask;
`endif

    // Encoder side
    modport slave (
        input  in_valid, data_in, out_ready,
`ifdef HAMMING_ERR_INJECT_EN
        input  inj_en, inj_mask,
`endif
        output in_ready, out_valid, code_out
    );

    // Producer / consumer side
    modport master (
        output in_valid, data_in, out_ready,
`ifdef HAMMING_ERR_INJECT_EN
        output inj_en, inj_mask,
`endif
        input  in_ready, out_valid, code_out
    );

endinterface

// File: rtl/hamming_fifo.sv
// Show-ahead synchronous FIFO with registered head data, valid, ready and level.
// Full/empty come from the level counter; pointers wrap naturally.
module hamming_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       valid_o,
    output logic                       ready_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    // Next pointers/level, plus the head word as it will look after this edge
    always_comb begin
        push     = push_i && ready_q;
        pop      = pop_i && valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = '0;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        valid_d = (level_d != '0);
        ready_d = (level_d != LVL_W'(DEPTH));
        // The new head is the word being written now when it lands at rd_ptr_d
        if (!valid_d)
            rdata_d = '0;
        else if (push && (wr_ptr_q == rd_ptr_d))
            rdata_d = wdata_i;
        else
            rdata_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset; only entries behind valid pointers are read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = rdata_q;
    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign level_o = level_q;

endmodule

// File: rtl/hamming_encoder_tx.sv
// Transmit-side SECDED Hamming(8,4) encoder with codeword FIFO and delivery counter.
// Define HAMMING_ERR_INJECT_EN to XOR inj_mask into codewords accepted with inj_en=1.
module hamming_encoder_tx
    import hamming_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    hamming_encoder_tx_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              word_count
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [CODE_W-1:0] code_c;
    logic [CODE_W-1:0] wdata_c;
    logic [CODE_W-1:0] head;
    logic              head_valid;
    logic              fifo_ready;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  count_q, count_d;

    assign code_c = hamming_encode(bus.data_in);

`ifdef HAMMING_ERR_INJECT_EN
    assign wdata_c = bus.inj_en ? (code_c ^ bus.inj_mask) : code_c;
`else
    assign wdata_c = code_c;
`endif

    hamming_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rstn),
        .push_i  (bus.in_valid),
        .wdata_i (wdata_c),
        .pop_i   (bus.out_ready),
        .rdata_o (head),
        .valid_o (head_valid),
        .ready_o (fifo_ready),
        .level_o (level)
    );

    // Delivered-word counter, wraps from all-ones to zero
    always_comb begin
        count_d = count_q;
        if (head_valid && bus.out_ready) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) count_q <= '0;
        else       count_q <= count_d;
    end

    assign bus.in_ready  = fifo_ready;
    assign bus.out_valid = head_valid;
    assign bus.code_out  = head;
    assign fifo_level    = level;
    assign word_count    = count_q;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Directed self-checking bench for hamming_encoder_tx (FIFO_DEPTH=4, CNT_W=4).
// Injection checks are built only when HAMMING_ERR_INJECT_EN is defined.
module tb_hamming_encoder_tx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;

    logic clk;
    logic rstn;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CW-1:0]          word_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    // Hand-computed codewords for d = 0..F
    logic [7:0] code_tbl [16] = '{8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
                                  8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF};

    hamming_encoder_tx_if bus ();

    hamming_encoder_tx #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus.slave),
        .fifo_level (fifo_level),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn          = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = 4'hB;
        bus.out_ready = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        bus.inj_en    = 1'b0;
        bus.inj_mask  = 8'h00;
`endif
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        step(); step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_code", 32'(bus.code_out), 32'h00);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_count", 32'(word_count), 32'h0);

        // Release: ready rises on the first edge, nothing accepted at it
        rstn = 1'b1;
        step();
        chk("rel_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rel_out_valid", 32'(bus.out_valid), 32'h0);
        step();
        chk("first_B_valid", 32'(bus.out_valid), 32'h1);
        chk("first_B_code", 32'(bus.code_out), 32'h55);
        bus.data_in = 4'h0;
        step();
        chk("two_level", 32'(fifo_level), 32'h2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step(); exp_cnt++;
        chk("d0_code", 32'(bus.code_out), 32'h00);
        chk("d0_valid", 32'(bus.out_valid), 32'h1);
        step(); exp_cnt++;
        chk("drain_valid", 32'(bus.out_valid), 32'h0);
        chk("cnt_2", 32'(word_count), 32'(exp_cnt % 16));

        // Sweep 1, 8, F
        bus.in_valid = 1'b1;
        bus.data_in  = 4'h1; step();
        chk("sweep_87", 32'(bus.code_out), 32'h87);
        bus.data_in  = 4'h8; step(); exp_cnt++;
        chk("sweep_4B", 32'(bus.code_out), 32'h4B);
        bus.data_in  = 4'hF; step(); exp_cnt++;
        chk("sweep_FF", 32'(bus.code_out), 32'hFF);
        bus.in_valid = 1'b0; step(); exp_cnt++;
        chk("sweep_cnt", 32'(word_count), 32'(exp_cnt % 16));

        // All 16 values streamed back-to-back: level stays 1
        bus.in_valid = 1'b1;
        for (int d = 0; d < 16; d++) begin
            bus.data_in = 4'(d);
            step();
            if (d > 0) exp_cnt++;
            chk($sformatf("enc_%0h", d), 32'(bus.code_out), 32'(code_tbl[d]));
            chk($sformatf("stream_lvl_%0h", d), 32'(fifo_level), 32'h1);
        end
        bus.in_valid = 1'b0; step(); exp_cnt++;
        chk("stream_cnt", 32'(word_count), 32'(exp_cnt % 16));
        chk("stream_empty", 32'(bus.out_valid), 32'h0);

        // Fill with output stalled: 5 offers, 4 accepted
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int d = 1; d <= 5; d++) begin
            bus.data_in = 4'(d);
            step();
            chk($sformatf("stall_head_%0d", d), 32'(bus.code_out), 32'h87);
        end
        chk("full_level", 32'(fifo_level), 32'h4);
        chk("full_in_ready", 32'(bus.in_ready), 32'h0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step(); exp_cnt++;
        chk("pop_2", 32'(bus.code_out), 32'h99);
        chk("pop_ready_back", 32'(bus.in_ready), 32'h1);
        step(); exp_cnt++;
        chk("pop_3", 32'(bus.code_out), 32'h1E);
        step(); exp_cnt++;
        chk("pop_4", 32'(bus.code_out), 32'hAA);
        step(); exp_cnt++;
        chk("pop_end_valid", 32'(bus.out_valid), 32'h0);
        chk("pop_end_level", 32'(fifo_level), 32'h0);
        chk("pop_end_code", 32'(bus.code_out), 32'h00);

        // 17 transfers on a 4-bit counter: wraps past zero
        bus.in_valid = 1'b1;
        bus.data_in  = 4'h6;
        step();
        for (int i = 0; i < 16; i++) begin
            step(); exp_cnt++;
        end
        bus.in_valid = 1'b0; step(); exp_cnt++;
        chk("wrap_cnt", 32'(word_count), 32'(exp_cnt % 16));

        // Reset with 3 words buffered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        step(); step(); step();
        chk("pre_rst_level", 32'(fifo_level), 32'h3);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_level", 32'(fifo_level), 32'h0);
        chk("mid_rst_code", 32'(bus.code_out), 32'h00);
        chk("mid_rst_cnt", 32'(word_count), 32'h0);
        step();
        rstn = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk("post_rst_empty", 32'(bus.out_valid), 32'h0);

`ifdef HAMMING_ERR_INJECT_EN
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.inj_en    = 1'b1;
        bus.data_in   = 4'hB;
        bus.inj_mask  = 8'h04;
        step();
        chk("inj_single", 32'(bus.code_out), 32'h51);
        bus.inj_mask  = 8'h03;
        step();
        chk("inj_double", 32'(bus.code_out), 32'h56);
        bus.inj_en    = 1'b0;
        step();
        chk("inj_off", 32'(bus.code_out), 32'h55);
        bus.in_valid  = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_encoder_tx.md
Name: hamming_encoder_tx

Overview:
- Transmit-side SECDED Hamming(8,4) encoder; the partner of the team's Hamming decoder.
- Accepts 4-bit data words over a valid/ready handshake and encodes each into an 8-bit codeword.
- Buffers codewords in a small FIFO and presents them over a valid/ready output handshake toward the link/decoder side.
- Provides a free-running count of delivered codewords for bring-up.

Parameters:
- FIFO_DEPTH, 4, codeword buffer entries; power of two, >= 2.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  data_in holds a word to encode.
- in_ready  out  1  encoder can accept a word this cycle.
- data_in  in  4  payload d[3:0].
- out_valid  out  1  code_out holds a valid codeword.
- out_ready  in  1  downstream accepts code_out this cycle.
- code_out  out  8  codeword c[7:0].
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of buffered codewords.
- word_count  out  CNT_W  codewords delivered since reset.

Behaviour:
- One clock domain (clk).
- Reset: rstn is asynchronous and active-low. While low:
  - FIFO pointers cleared, contents don't-care.
  - out_valid=0, in_ready=0, fifo_level=0, word_count=0.
  - code_out=8'h00.
  - in_ready rises on the first clk edge after rstn deasserts.
- Codeword bit map (fixed, must match the decoder):
  - c[6]=d[3], c[5]=d[2], c[4]=d[1], c[2]=d[0].
  - c[3]=c6^c5^c4; c[1]=c6^c5^c2; c[0]=c6^c4^c2.
  - c[7]=XOR of c[6:0], so the overall parity across c[7:0] is even.
- Encoding is combinational on data_in. The codeword is written into the FIFO on accept.
- Input handshake:
  - accept = in_valid && in_ready.
  - in_ready = !full. It is registered-equivalent: derived from the FIFO state only, never from in_valid or out_ready.
- Output handshake:
  - Show-ahead FIFO: out_valid = !empty, code_out = head entry.
  - code_out = 8'h00 when empty.
  - A transfer is out_valid && out_ready.
  - code_out and out_valid are held stable while out_valid && !out_ready.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N when the FIFO was empty. There is no combinational in-to-out path.
- Simultaneous push and pop when neither full nor empty: both happen, level unchanged.
- Push and pop at level FIFO_DEPTH-1: both happen, level unchanged.
- Full: in_ready=0, so no push. A pop in the same cycle frees a slot, visible next cycle.
- Empty: out_valid=0. A push at the same edge makes the word visible next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The full/empty distinction comes from the level counter.
- word_count increments on each output transfer and wraps from all-ones to 0.
- Reset mid-operation: buffered words are discarded; no partial codeword is ever driven.

Optional Feature:
- HAMMING_ERR_INJECT_EN defined:
  - Adds inputs inj_en (1) and inj_mask (8).
  - On accept with inj_en=1, the FIFO stores codeword ^ inj_mask.
  - Purpose: exercise decoder correct/detect paths.
- Not defined: these ports do not exist and codewords are always clean.

Decomposition:
- Package hamming_pkg holds:
  - localparams for data and parity bit positions (data at 6,5,4,2; parity at 3,1,0; overall at 7).
  - function hamming_encode(d[3:0]) returning [7:0].
  - The decoder is to import the same package.
- One sub-module: hamming_fifo, a synchronous show-ahead FIFO parameterized by width and depth, with level output.
- The top holds the encoder, handshake glue, counter and injection logic.

Test Plan:
- Reset with in_valid=1 held: in_ready=0 and out_valid=0 while rstn=0. After release, first accept of d=4'hB -> code_out=8'h55 one cycle later; d=4'h0 -> 8'h00.
- Sweep d=4'h1, 4'h8, 4'hF with out_ready=1 -> codes 8'h87, 8'h4B, 8'hFF in order, one per cycle. word_count reaches 3. All 16 values must match hamming_encode.
- out_ready=0 with 5 pushes at FIFO_DEPTH=4 -> 4 accepted, in_ready=0, fifo_level=4, code_out stable. Then out_ready=1 -> 4 words out in FIFO order, level back to 0.
- Continuous in_valid=1 and out_ready=1 -> steady one word per cycle, level stays 1, no drop or duplicate.
- Preload word_count to near wrap (CNT_W=4 build): 17 transfers -> count reads 1. Assert rstn low with 3 words buffered -> out_valid=0 immediately, level 0.
- With HAMMING_ERR_INJECT_EN: d=4'hB, inj_mask=8'h04 -> code_out=8'h51, and the decoder flags correctable. inj_mask=8'h03 -> 8'h56, and the decoder flags uncorrectable.
